// File: rtl/prty_scrub_ctrl_if.sv
// Shared RAM read-port bundle between the scrubber and the RAM/user side.
// Latency: none. The interface only carries signals.
// Backpressure: usr_rd_req from the user side blocks the scrubber strobe in the same cycle.
interface prty_scrub_ctrl_if #(
   parameter int ADDR_WTH = 10,
   parameter int WORD_WTH = 288
);
   logic                usr_rd_req;
   logic                scrub_rd_en;
   logic [ADDR_WTH-1:0] scrub_rd_addr;
   logic [WORD_WTH-1:0] mem_rd_data;

   // Scrubber side: drives the read strobe and address, receives read data.
   modport master (
      output scrub_rd_en,
      output scrub_rd_addr,
      input  usr_rd_req,
      input  mem_rd_data
   );

   // RAM/user side: owns user requests and returns read data.
   modport slave (
      input  scrub_rd_en,
      input  scrub_rd_addr,
      output usr_rd_req,
      output mem_rd_data
   );
endinterface

// File: rtl/prty_scrub_ctrl.sv
// Background parity scrubber: walks RAM addresses, rechecks per-cell even parity, and logs errors.
// Latency: one read per cfg_interval + RD_LAT + 3 cycles; the error log updates RD_LAT + 2 cycles after the strobe.
// Backpressure: usr_rd_req stalls the scrubber in ISSUE with no strobe; the user path always wins.
module prty_scrub_ctrl #(
   parameter int DATA_WTH = 279,
   parameter int CELL_WTH = 32,
   parameter int ADDR_WTH = 10,
   parameter int RD_LAT   = 2,
   localparam int PRTY_WTH = (DATA_WTH + CELL_WTH - 1) / CELL_WTH
) (
   input  logic                clk_sys,
   input  logic                rst,
   input  logic                cfg_scrub_en,
   input  logic [15:0]         cfg_interval,
   input  logic [ADDR_WTH-1:0] cfg_addr_max,
   input  logic                err_clr,
   output logic                err_flag,
   output logic [15:0]         err_cnt,
   output logic [ADDR_WTH-1:0] err_addr,
   output logic                pass_done,
   prty_scrub_ctrl_if.master   mem_if
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2,
      CHK   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         wait_cnt_q, wait_cnt_d;
   logic [ADDR_WTH-1:0] addr_q, addr_d;
   logic [2:0]          chk_cnt_q, chk_cnt_d;
   logic                mis_q, mis_d;
   logic                pass_done_q, pass_done_d;
   logic                err_flag_q, err_flag_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   logic [ADDR_WTH-1:0] err_addr_q, err_addr_d;

   logic                rd_en;
   logic                log_cyc;
   logic                err_upd;
   logic [PRTY_WTH-1:0] calc_prty;
   logic [PRTY_WTH-1:0] stored_prty;
   logic                mismatch;

   // Recompute one even-parity bit per data cell; the top cell may be narrower than CELL_WTH.
   for (genvar gi = 0; gi < PRTY_WTH; gi++) begin : g_cell
      localparam int LO = gi * CELL_WTH;
      localparam int HI = (LO + CELL_WTH - 1 > DATA_WTH - 1) ? DATA_WTH - 1 : LO + CELL_WTH - 1;
      assign calc_prty[gi] = ^mem_if.mem_rd_data[HI:LO];
   end

   assign stored_prty = mem_if.mem_rd_data[DATA_WTH+PRTY_WTH-1:DATA_WTH];
   assign mismatch    = |(calc_prty ^ stored_prty);

   // Last CHK cycle: the sampled result is logged and the scan moves on.
   assign log_cyc = (state_q == CHK) && (chk_cnt_q == 3'(RD_LAT));
   assign err_upd = log_cyc & mis_q;

   // Scan FSM: interval wait, arbitration-aware strobe, read-latency wait and address advance.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      addr_d      = addr_q;
      chk_cnt_d   = chk_cnt_q;
      mis_d       = mis_q;
      pass_done_d = 1'b0;
      rd_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_scrub_en) begin
               state_d    = WAIT;
               wait_cnt_d = cfg_interval;
            end
         end
         WAIT: begin
            if (!cfg_scrub_en) begin
               state_d = IDLE;
               addr_d  = '0;
            end else if (wait_cnt_q == 16'd0) begin
               state_d = ISSUE;
            end else begin
               wait_cnt_d = wait_cnt_q - 16'd1;
            end
         end
         ISSUE: begin
            // A disable in this cycle suppresses the strobe so no read is left unchecked.
            if (!cfg_scrub_en) begin
               state_d = IDLE;
               addr_d  = '0;
            end else if (!mem_if.usr_rd_req) begin
               rd_en     = 1'b1;
               state_d   = CHK;
               chk_cnt_d = '0;
            end
         end
         CHK: begin
            if (chk_cnt_q == 3'(RD_LAT - 1)) begin
               mis_d = mismatch;
            end
            if (log_cyc) begin
               if (!cfg_scrub_en) begin
                  state_d = IDLE;
                  addr_d  = '0;
               end else begin
                  state_d    = WAIT;
                  wait_cnt_d = cfg_interval;
                  // >= also catches an address stranded above a freshly lowered limit.
                  if (addr_q >= cfg_addr_max) begin
                     addr_d      = '0;
                     pass_done_d = 1'b1;
                  end else begin
                     addr_d = addr_q + ADDR_WTH'(1);
                  end
               end
            end else begin
               chk_cnt_d = chk_cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase
   end

   // Error log: a new error takes precedence over a coincident clear.
   always_comb begin
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      if (err_upd) begin
         err_flag_d = 1'b1;
         if (err_clr) begin
            err_cnt_d = 16'd1;
         end else if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
         if (err_clr || !err_flag_q) begin
            err_addr_d = addr_q;
         end
      end else if (err_clr) begin
         err_flag_d = 1'b0;
         err_cnt_d  = '0;
         err_addr_d = '0;
      end
   end

   // State registers with synchronous reset; any read in flight is dropped by returning to IDLE.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         addr_q      <= '0;
         chk_cnt_q   <= '0;
         mis_q       <= 1'b0;
         pass_done_q <= 1'b0;
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         addr_q      <= addr_d;
         chk_cnt_q   <= chk_cnt_d;
         mis_q       <= mis_d;
         pass_done_q <= pass_done_d;
         err_flag_q  <= err_flag_d;
         err_cnt_q   <= err_cnt_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign mem_if.scrub_rd_en   = rd_en;
   assign mem_if.scrub_rd_addr = addr_q;
   assign err_flag             = err_flag_q;
   assign err_cnt              = err_cnt_q;
   assign err_addr             = err_addr_q;
   assign pass_done            = pass_done_q;

endmodule

// File: tb/tb_prty_scrub_ctrl.sv
// Directed bench for prty_scrub_ctrl with a 4-word RAM model of read latency 2.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
// Backpressure: usr_rd_req is driven directly to exercise the stall path.
module tb_prty_scrub_ctrl;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_scrub_en = 1'b0;
   logic [15:0] cfg_interval = 16'd0;
   logic [9:0]  cfg_addr_max = 10'd3;
   logic        err_clr = 1'b0;
   logic        err_flag;
   logic [15:0] err_cnt;
   logic [9:0]  err_addr;
   logic        pass_done;

   int checks = 0;
   int failures = 0;

   prty_scrub_ctrl_if #(.ADDR_WTH(10), .WORD_WTH(288)) mif ();

   prty_scrub_ctrl dut (
      .clk_sys      (clk_sys),
      .rst          (rst),
      .cfg_scrub_en (cfg_scrub_en),
      .cfg_interval (cfg_interval),
      .cfg_addr_max (cfg_addr_max),
      .err_clr      (err_clr),
      .err_flag     (err_flag),
      .err_cnt      (err_cnt),
      .err_addr     (err_addr),
      .pass_done    (pass_done),
      .mem_if       (mif.master)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM model: words are {prty[8:0], data[278:0]}; two-stage read pipeline.
   logic [287:0] mem [0:3];
   logic [287:0] pipe0 = '0;
   logic [287:0] pipe1 = '0;
   always @(posedge clk_sys) begin
      pipe0 <= mif.scrub_rd_en ? mem[mif.scrub_rd_addr[1:0]] : '0;
      pipe1 <= pipe0;
   end
   assign mif.mem_rd_data = pipe1;

   // Strobe/pulse monitor.
   int     cyc_cnt = 0;
   int     pass_cnt = 0;
   int     overlap = 0;
   int     rd_addr_q[$];
   int     rd_time_q[$];
   always @(negedge clk_sys) begin
      cyc_cnt++;
      if (mif.scrub_rd_en) begin
         rd_addr_q.push_back(int'(mif.scrub_rd_addr));
         rd_time_q.push_back(cyc_cnt);
         if (mif.usr_rd_req) overlap++;
      end
      if (pass_done) pass_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Clean words: parity hand-computed per cell.
   task automatic load_clean();
      logic [278:0] d;
      mem[0] = '0;
      d = 279'd1;
      mem[1] = {9'h001, d};
      d = '0; d[278] = 1'b1;
      mem[2] = {9'h100, d};
      d = '0; d[31] = 1'b1; d[32] = 1'b1;
      mem[3] = {9'h003, d};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cfg_scrub_en = 1'b0;
      mif.usr_rd_req = 1'b0;
      err_clr = 1'b0;
      cyc(3);
      rst = 1'b0;
      rd_addr_q.delete();
      rd_time_q.delete();
   endtask

   task automatic wait_pass(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_sys);
         if (pass_done) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_pass_timeout got=no_pass_done want=pass_done", nm);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mif.usr_rd_req = 1'b0;
      cyc(2);
      @(negedge clk_sys);
      checks++;
      if ({err_flag, err_cnt, err_addr, pass_done, mif.scrub_rd_en, mif.scrub_rd_addr} !== 39'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", {err_flag, err_cnt, err_addr, pass_done, mif.scrub_rd_en, mif.scrub_rd_addr});
      end
      rst = 1'b0;
      cyc(3);
      @(negedge clk_sys);
      checks++;
      if (mif.scrub_rd_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_strobe got=%b want=0", mif.scrub_rd_en);
      end
   endtask

   task automatic test_clean_pass();
      int pc0;
      do_reset();
      load_clean();
      pc0 = pass_cnt;
      cfg_interval = 16'd0;
      cfg_addr_max = 10'd3;
      cfg_scrub_en = 1'b1;
      wait_pass("t1");
      cfg_scrub_en = 1'b0;
      cyc(10);
      @(negedge clk_sys);
      checks++;
      if (rd_addr_q.size() != 4) begin
         failures++;
         $display("FAIL t1_read_count got=%0d want=4", rd_addr_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_addr_q[i] != i) begin
               failures++;
               $display("FAIL t1_read_addr[%0d] got=%0d want=%0d", i, rd_addr_q[i], i);
            end
         end
         checks++;
         if (rd_time_q[1] - rd_time_q[0] != 5) begin
            failures++;
            $display("FAIL t1_read_spacing got=%0d want=5", rd_time_q[1] - rd_time_q[0]);
         end
      end
      checks++;
      if (pass_cnt - pc0 != 1) begin
         failures++;
         $display("FAIL t1_pass_done_count got=%0d want=1", pass_cnt - pc0);
      end
      checks++;
      if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin
         failures++;
         $display("FAIL t1_no_errors got_cnt=%0d got_flag=%b want=0/0", err_cnt, err_flag);
      end
   endtask

   task automatic test_partial_cell_err();
      do_reset();
      load_clean();
      mem[2][279+8] = ~mem[2][279+8];
      cfg_interval = 16'd0;
      cfg_addr_max = 10'd3;
      cfg_scrub_en = 1'b1;
      wait_pass("t2");
      cfg_scrub_en = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (err_cnt !== 16'd1 || err_flag !== 1'b1 || err_addr !== 10'd2) begin
         failures++;
         $display("FAIL t2_partial_cell got=%0d/%b/%0d want=1/1/2", err_cnt, err_flag, err_addr);
      end
   endtask

   task automatic test_first_err_kept();
      do_reset();
      load_clean();
      mem[1][279] = ~mem[1][279];
      mem[3][100] = ~mem[3][100];
      cfg_interval = 16'd0;
      cfg_scrub_en = 1'b1;
      wait_pass("t3");
      cfg_scrub_en = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (err_cnt !== 16'd2 || err_flag !== 1'b1 || err_addr !== 10'd1) begin
         failures++;
         $display("FAIL t3_two_errors got=%0d/%b/%0d want=2/1/1", err_cnt, err_flag, err_addr);
      end
   endtask

   task automatic test_usr_priority();
      int viol;
      viol = 0;
      do_reset();
      load_clean();
      cfg_interval = 16'd3;
      mif.usr_rd_req = 1'b1;
      cfg_scrub_en = 1'b1;
      repeat (10) begin
         @(negedge clk_sys);
         if (mif.scrub_rd_en !== 1'b0) viol++;
      end
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL t4_strobe_while_user got=%0d want=0", viol);
      end
      @(posedge clk_sys);
      #1;
      mif.usr_rd_req = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (mif.scrub_rd_en !== 1'b1 || mif.scrub_rd_addr !== 10'd0) begin
         failures++;
         $display("FAIL t4_strobe_after_release got=%b@%0d want=1@0", mif.scrub_rd_en, mif.scrub_rd_addr);
      end
      @(negedge clk_sys);
      checks++;
      if (mif.scrub_rd_en !== 1'b0) begin
         failures++;
         $display("FAIL t4_single_strobe got=%b want=0", mif.scrub_rd_en);
      end
      wait_pass("t4");
      cfg_scrub_en = 1'b0;
      cfg_interval = 16'd0;
      @(negedge clk_sys);
      checks++;
      if (rd_addr_q.size() != 4 || rd_addr_q[0] != 0 || rd_addr_q[1] != 1 || overlap != 0) begin
         failures++;
         $display("FAIL t4_sequence got_n=%0d overlap=%0d want_n=4 overlap=0", rd_addr_q.size(), overlap);
      end
   endtask

   task automatic test_saturate_and_clr();
      do_reset();
      load_clean();
      mem[0][279] = ~mem[0][279];
      mem[1][279] = ~mem[1][279];
      mem[2][279+8] = ~mem[2][279+8];
      mem[3][100] = ~mem[3][100];
      force dut.err_cnt_q = 16'hFFFD;
      cyc(1);
      release dut.err_cnt_q;
      @(negedge clk_sys);
      checks++;
      if (err_cnt !== 16'hFFFD) begin
         failures++;
         $display("FAIL t5_preset got=%h want=fffd", err_cnt);
      end
      cfg_interval = 16'd0;
      cfg_scrub_en = 1'b1;
      wait_pass("t5");
      cfg_scrub_en = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (err_cnt !== 16'hFFFF || err_flag !== 1'b1 || err_addr !== 10'd0) begin
         failures++;
         $display("FAIL t5_saturate got=%h/%b/%0d want=ffff/1/0", err_cnt, err_flag, err_addr);
      end
      cyc(3);
      cfg_scrub_en = 1'b1;
      // Address 1 logs on the 11th rising edge after enabling from IDLE.
      cyc(10);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      cfg_scrub_en = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (err_cnt !== 16'd1 || err_flag !== 1'b1 || err_addr !== 10'd1) begin
         failures++;
         $display("FAIL t5_clr_vs_error got=%0d/%b/%0d want=1/1/1", err_cnt, err_flag, err_addr);
      end
      cyc(6);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (err_cnt !== 16'd0 || err_flag !== 1'b0 || err_addr !== 10'd0) begin
         failures++;
         $display("FAIL t5_clear got=%0d/%b/%0d want=0/0/0", err_cnt, err_flag, err_addr);
      end
   endtask

   task automatic test_disable_in_chk();
      int  pc0;
      bit  seen;
      do_reset();
      load_clean();
      mem[2][279+8] = ~mem[2][279+8];
      pc0 = pass_cnt;
      cfg_interval = 16'd0;
      cfg_scrub_en = 1'b1;
      // Address 2 is in CHK after the 14th rising edge.
      cyc(14);
      cfg_scrub_en = 1'b0;
      cyc(12);
      @(negedge clk_sys);
      checks++;
      if (err_cnt !== 16'd1 || err_flag !== 1'b1 || err_addr !== 10'd2) begin
         failures++;
         $display("FAIL t6_logged got=%0d/%b/%0d want=1/1/2", err_cnt, err_flag, err_addr);
      end
      checks++;
      if (pass_cnt != pc0 || rd_addr_q.size() != 3) begin
         failures++;
         $display("FAIL t6_stopped got_pass=%0d got_reads=%0d want=0/3", pass_cnt - pc0, rd_addr_q.size());
      end
      cyc(1);
      cfg_scrub_en = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_sys);
         if (mif.scrub_rd_en) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || mif.scrub_rd_addr !== 10'd0) begin
         failures++;
         $display("FAIL t6_restart got_seen=%b addr=%0d want=1/0", seen, mif.scrub_rd_addr);
      end
      cfg_scrub_en = 1'b0;
      cyc(8);
   endtask

   initial begin
      mif.usr_rd_req = 1'b0;
      load_clean();
      test_reset();
      test_clean_pass();
      test_partial_cell_err();
      test_first_err_kept();
      test_usr_priority();
      test_saturate_and_clr();
      test_disable_in_chk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
